hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Hazard detection and forwarding controller for the 5-stage pipelined core. It consumes the register tags that decode hands to the pipeline registers and keeps its own E/M/W shadow copy of destination tags and write-enables. From that copy it generates stall, flush and forwarding-select signals for the datapath. It sits beside the datapath pipeline registers, reading the same tag fields they carry, and closes the loop the pipeline registers leave open.

## Interface
- RW, 4, register tag width (16 architectural registers)
- PC_TAG, 15, tag that is never hazard-checked or forwarded (PC reads)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears all shadow state
- valid_d  in  1  decode holds a real instruction this cycle
- ra1_d  in  RW  decode source tag A
- ra2_d  in  RW  decode source tag B
- wa3_d  in  RW  decode destination tag
- regwrite_d  in  1  decode instruction writes wa3_d
- memtoreg_d  in  1  decode instruction is a load
- pcsrc_e  in  1  branch taken, resolved in E this cycle
- stall_f  out  1  hold fetch PC
- stall_d  out  1  hold F/D pipeline register
- flush_d  out  1  clear F/D pipeline register
- flush_e  out  1  clear D/E pipeline register
- fwd_a_e  out  2  operand A select in E: 00 regfile, 10 from M, 01 from W
- fwd_b_e  out  2  operand B select in E, same encoding

## Operation
- Shadow state, all registered: E slot {ra1_e, ra2_e, wa3_e, regwrite_e, memtoreg_e}, M slot {wa3_m, regwrite_m}, W slot {wa3_w, regwrite_w}.
- Every posedge: W <= M, M <= E.
- E slot load: if flush_e or !valid_d, load a bubble (all tags 0, regwrite_e=0, memtoreg_e=0). Otherwise load the decode fields.
- Load-use (ldstall): memtoreg_e & regwrite_e & wa3_e != PC_TAG & valid_d & (ra1_d == wa3_e | ra2_d == wa3_e).
- stall_f = stall_d = ldstall & !pcsrc_e.
- flush_d = pcsrc_e.
- flush_e = ldstall | pcsrc_e.
- Forward A: 10 if regwrite_m & wa3_m == ra1_e & ra1_e != PC_TAG. Else 01 if the same test passes with the W slot. Else 00. Forward B uses ra2_e with identical rules. M has priority over W.
- Stall and flush outputs are combinational from shadow state and decode inputs. Forward selects depend on shadow state only.
- A source tag equal to PC_TAG never stalls and never forwards.

## Timing
- Reset, asynchronous: all shadow regwrite and memtoreg bits are 0 and all tags are 0. As a result every output is 0 while reset is asserted and in the first cycle after release.
- Load-use penalty is exactly one cycle. Cycle t: stall and flush_e are asserted. Cycle t+1: the load has moved to M, so ldstall clears, and the consumer gets fwd=01 one cycle later, when the load reaches W.
- Branch penalty is two cycles. flush_d and flush_e are asserted together in the cycle pcsrc_e=1.
- Branch and load-use in the same cycle: the branch wins. flush_d=flush_e=1 and stall_f=stall_d=0, because the stalled instruction is on the wrong path.
- M and W both match the same E source: select 10.
- Reset asserted mid-stall: stall deasserts immediately (asynchronous) and the pipeline resumes with an empty shadow.

## Configuration
- HAZARD_PERF_EN defined: adds outputs stall_cnt (out, 32) and flush_cnt (out, 32).
  - stall_cnt increments on each cycle with stall_d=1.
  - flush_cnt increments on each cycle with pcsrc_e=1.
  - Both counters wrap at 2^32 and reset to 0.
- HAZARD_PERF_EN not defined: the counter ports and logic do not exist; all other behaviour is identical.

## Test plan
- Load r2 (memtoreg_d=1, wa3_d=2), next cycle ADD with ra1_d=2 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle. Two cycles later fwd_a_e=01.
- ADD writes r3, next instruction reads ra2_d=3 -> no stall, fwd_b_e=10 in its E cycle. An instruction issued 2 later reading r3 -> fwd=01.
- Back-to-back writes to r5 followed by a read of r5 (M and W both match) -> fwd_a_e=10.
- Load r4 followed by a use of r4, with pcsrc_e=1 in the stall cycle -> flush_d=flush_e=1, stall_f=0. The next E slot is a bubble.
- Load with wa3=15 followed by a read of ra1_d=15 -> no stall, fwd=00. valid_d=0 with matching tags -> no stall.
- Reset asserted during an active stall -> all outputs 0 within the same cycle. With HAZARD_PERF_EN, after 3 stalls and 2 branches stall_cnt=3 and flush_cnt=2, and both read 0 after reset.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: hazard detection and forwarding controller for the 5-stage core.
// Keeps a shadow E/M/W copy of register tags and write enables, and derives
// stall, flush and forwarding selects for the datapath pipeline registers.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset (clears shadow)
//   valid_d               decode holds a real instruction
//   ra1_d, ra2_d, wa3_d   decode source A/B and destination tags
//   regwrite_d            decode instruction writes wa3_d
//   memtoreg_d            decode instruction is a load
//   pcsrc_e               branch taken, resolved in E
//   stall_f, stall_d      hold fetch PC / F-D register (combinational)
//   flush_d, flush_e      clear F-D / D-E register (combinational)
//   fwd_a_e, fwd_b_e      operand select in E: 00 regfile, 10 from M, 01 from W
//   stall_cnt, flush_cnt  performance counters, present only with HAZARD_PERF_EN
//
// Build option: define HAZARD_PERF_EN to add the stall/branch counters.
module hazard_fwd_unit #(
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_d,
  input  logic [RW-1:0] ra1_d,
  input  logic [RW-1:0] ra2_d,
  input  logic [RW-1:0] wa3_d,
  input  logic          regwrite_d,
  input  logic          memtoreg_d,
  input  logic          pcsrc_e,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_d,
  output logic          flush_e,
  output logic [1:0]    fwd_a_e,
`ifdef HAZARD_PERF_EN
  output logic [1:0]    fwd_b_e,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`else
  output logic [1:0]    fwd_b_e
`endif
);

  // Tag used for PC reads; never hazard-checked or forwarded.
  localparam logic [RW-1:0] PC_TAG = RW'(15);

  logic [RW-1:0] ra1_e_q, ra1_e_d;
  logic [RW-1:0] ra2_e_q, ra2_e_d;
  logic [RW-1:0] wa3_e_q, wa3_e_d;
  logic          regwrite_e_q, regwrite_e_d;
  logic          memtoreg_e_q, memtoreg_e_d;
  logic [RW-1:0] wa3_m_q, wa3_m_d;
  logic          regwrite_m_q, regwrite_m_d;
  logic [RW-1:0] wa3_w_q, wa3_w_d;
  logic          regwrite_w_q, regwrite_w_d;

  logic          ldstall;

  // Forward select for one E source: M beats W, PC tag never forwards.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src,
                                         input logic          rw_m,
                                         input logic [RW-1:0] wa_m,
                                         input logic          rw_w,
                                         input logic [RW-1:0] wa_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != PC_TAG) begin
      if (rw_m && (wa_m == src))      sel = 2'b10;
      else if (rw_w && (wa_w == src)) sel = 2'b01;
    end
    return sel;
  endfunction

  // Load-use detect against the load sitting in E.
  always_comb begin
    ldstall = 1'b0;
    if (memtoreg_e_q && regwrite_e_q && (wa3_e_q != PC_TAG) && valid_d &&
        ((ra1_d == wa3_e_q) || (ra2_d == wa3_e_q)))
      ldstall = 1'b1;
  end

  // A taken branch squashes the stalled instruction, so it overrides the stall.
  assign stall_f = ldstall & ~pcsrc_e;
  assign stall_d = ldstall & ~pcsrc_e;
  assign flush_d = pcsrc_e;
  assign flush_e = ldstall | pcsrc_e;

  assign fwd_a_e = fwd_sel(ra1_e_q, regwrite_m_q, wa3_m_q, regwrite_w_q, wa3_w_q);
  assign fwd_b_e = fwd_sel(ra2_e_q, regwrite_m_q, wa3_m_q, regwrite_w_q, wa3_w_q);

  // Shadow pipeline advance; E takes a bubble on flush or empty decode.
  always_comb begin
    wa3_w_d      = wa3_m_q;
    regwrite_w_d = regwrite_m_q;
    wa3_m_d      = wa3_e_q;
    regwrite_m_d = regwrite_e_q;
    ra1_e_d      = '0;
    ra2_e_d      = '0;
    wa3_e_d      = '0;
    regwrite_e_d = 1'b0;
    memtoreg_e_d = 1'b0;
    if (!flush_e && valid_d) begin
      ra1_e_d      = ra1_d;
      ra2_e_d      = ra2_d;
      wa3_e_d      = wa3_d;
      regwrite_e_d = regwrite_d;
      memtoreg_e_d = memtoreg_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra1_e_q      <= '0;
      ra2_e_q      <= '0;
      wa3_e_q      <= '0;
      regwrite_e_q <= 1'b0;
      memtoreg_e_q <= 1'b0;
      wa3_m_q      <= '0;
      regwrite_m_q <= 1'b0;
      wa3_w_q      <= '0;
      regwrite_w_q <= 1'b0;
    end else begin
      ra1_e_q      <= ra1_e_d;
      ra2_e_q      <= ra2_e_d;
      wa3_e_q      <= wa3_e_d;
      regwrite_e_q <= regwrite_e_d;
      memtoreg_e_q <= memtoreg_e_d;
      wa3_m_q      <= wa3_m_d;
      regwrite_m_q <= regwrite_m_d;
      wa3_w_q      <= wa3_w_d;
      regwrite_w_q <= regwrite_w_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running event counters; wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d) stall_cnt_d = stall_cnt_q + 32'd1;
    if (pcsrc_e) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed vector table, hand-written
// reset/counter sequences, and randomized traffic against an in-flight
// instruction model (queue: index 0 = E, 1 = M, 2 = W).
module tb_hazard_fwd_unit;

  typedef struct packed {
    logic       valid;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       m2r;
    logic       pc;
  } in_t;

  typedef struct packed {
    logic       stall;
    logic       fd;
    logic       fe;
    logic [1:0] fa;
    logic [1:0] fb;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       m2r;
  } inst_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_d = 1'b0;
  logic [3:0] ra1_d = '0, ra2_d = '0, wa3_d = '0;
  logic       regwrite_d = 1'b0, memtoreg_d = 1'b0, pcsrc_e = 1'b0;
  logic       stall_f, stall_d, flush_d, flush_e;
  logic [1:0] fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_fwd_unit dut (
    .clk(clk), .reset(reset), .valid_d(valid_d),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .pcsrc_e(pcsrc_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e),
`ifdef HAZARD_PERF_EN
    .fwd_b_e(fwd_b_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
    .fwd_b_e(fwd_b_e)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  inst_t       flight[$];
  int unsigned exp_stall_cnt = 0;
  int unsigned exp_flush_cnt = 0;

  function automatic logic [1:0] src_sel(input logic [3:0] s, input inst_t m, input inst_t w);
    if (s == 4'd15) return 2'b00;
    if (m.rw && m.wa3 == s) return 2'b10;
    if (w.rw && w.wa3 == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model(input in_t x);
    inst_t e, m, w;
    logic  ld;
    out_t  r;
    e = flight[0];
    m = flight[1];
    w = flight[2];
    ld = e.m2r && e.rw && (e.wa3 != 4'd15) && x.valid &&
         ((x.ra1 == e.wa3) || (x.ra2 == e.wa3));
    r.stall = ld && !x.pc;
    r.fd    = x.pc;
    r.fe    = ld || x.pc;
    r.fa    = src_sel(e.ra1, m, w);
    r.fb    = src_sel(e.ra2, m, w);
    return r;
  endfunction

  function automatic logic [7:0] pack_act();
    return {stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e};
  endfunction

  function automatic logic [7:0] pack_exp(input out_t o);
    return {o.stall, o.stall, o.fd, o.fe, o.fa, o.fb};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    valid_d    = x.valid;
    ra1_d      = x.ra1;
    ra2_d      = x.ra2;
    wa3_d      = x.wa3;
    regwrite_d = x.rw;
    memtoreg_d = x.m2r;
    pcsrc_e    = x.pc;
  endtask

  task automatic model_clear();
    flight.delete();
    repeat (3) flight.push_back(inst_t'(0));
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
  endtask

  // One pipeline cycle: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic step(input in_t x, input string name, input bit use_tab, input out_t tab_o);
    out_t  m;
    inst_t nx;
    @(negedge clk);
    drive(x);
    #2;
    m = model(x);
    check(name, 64'(pack_act()), 64'(pack_exp(use_tab ? tab_o : m)));
    if (m.fe || !x.valid) nx = '0;
    else nx = {x.ra1, x.ra2, x.wa3, x.rw, x.m2r};
    if (m.stall) exp_stall_cnt++;
    if (x.pc) exp_flush_cnt++;
    @(posedge clk);
    flight.push_front(nx);
    void'(flight.pop_back());
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(in_t'(0));
    reset = 1'b1;
    #2;
    check("reset_outputs", 64'(pack_act()), 64'h0);
`ifdef HAZARD_PERF_EN
    @(posedge clk);
    #1;
    check("reset_counters", {stall_cnt, flush_cnt}, 64'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] a1, input logic [3:0] a2,
                              input logic [3:0] w, input logic rw, input logic m2r,
                              input logic pc, input logic st, input logic fd,
                              input logic fe, input logic [1:0] fa, input logic [1:0] fb);
    vec_t t;
    t.i = '{valid: v, ra1: a1, ra2: a2, wa3: w, rw: rw, m2r: m2r, pc: pc};
    t.o = '{stall: st, fd: fd, fe: fe, fa: fa, fb: fb};
    return t;
  endfunction

  function automatic logic [3:0] rtag();
    int unsigned r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  vec_t tab[15];

  initial begin
    in_t  x;
    out_t dummy;
    dummy = '0;
    model_clear();

    // Directed cycle-by-cycle program, starting from an empty pipeline.
    tab[0]  = mk(1, 0, 0, 2, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00); // load r2
    tab[1]  = mk(1, 2, 1, 6, 1, 0, 0,  1, 0, 1, 2'b00, 2'b00); // use r2: stall
    tab[2]  = mk(1, 2, 1, 6, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00); // held use: released
    tab[3]  = mk(1, 0, 0, 3, 1, 0, 0,  0, 0, 0, 2'b01, 2'b00); // use in E: load from W
    tab[4]  = mk(1, 1, 3, 7, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00); // reads r3 next
    tab[5]  = mk(1, 0, 3, 5, 1, 0, 0,  0, 0, 0, 2'b00, 2'b10); // r3 from M
    tab[6]  = mk(1, 0, 0, 5, 1, 0, 0,  0, 0, 0, 2'b00, 2'b01); // r3 from W
    tab[7]  = mk(1, 5, 0, 8, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00); // read r5
    tab[8]  = mk(1, 0, 0, 4, 1, 1, 0,  0, 0, 0, 2'b10, 2'b00); // r5 in M and W: M wins
    tab[9]  = mk(1, 4, 0, 9, 1, 0, 1,  0, 1, 1, 2'b00, 2'b00); // load-use + branch
    tab[10] = mk(1, 0, 0, 15, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00); // E bubble: no fwd of r4
    tab[11] = mk(1, 15, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00); // PC tag: no stall
    tab[12] = mk(1, 0, 0, 9, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00); // PC tag: no forward
    tab[13] = mk(0, 9, 9, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00); // invalid decode: no stall
    tab[14] = mk(1, 9, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00); // load behind a bubble

    do_reset();
    for (int k = 0; k < 15; k++) step(tab[k].i, $sformatf("vec%0d", k), 1'b1, tab[k].o);

    // Reset asserted while a load-use stall is active.
    do_reset();
    step('{valid: 1, ra1: 0, ra2: 0, wa3: 2, rw: 1, m2r: 1, pc: 0}, "rst_stall_load", 1'b0, dummy);
    @(negedge clk);
    drive('{valid: 1, ra1: 2, ra2: 0, wa3: 3, rw: 1, m2r: 0, pc: 0});
    #2;
    check("rst_stall_before", 64'(pack_act()), 64'(8'b1101_0000));
    reset = 1'b1;
    #1;
    check("rst_stall_async", 64'(pack_act()), 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();

    // Three load-use stalls and two branches.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step('{valid: 1, ra1: 0, ra2: 0, wa3: 1, rw: 1, m2r: 1, pc: 0}, "perf_load", 1'b0, dummy);
      step('{valid: 1, ra1: 0, ra2: 1, wa3: 2, rw: 1, m2r: 0, pc: 0}, "perf_use_stall", 1'b0, dummy);
      step('{valid: 1, ra1: 0, ra2: 1, wa3: 2, rw: 1, m2r: 0, pc: 0}, "perf_use_go", 1'b0, dummy);
    end
    step('{valid: 0, ra1: 0, ra2: 0, wa3: 0, rw: 0, m2r: 0, pc: 1}, "perf_br", 1'b0, dummy);
    step('{valid: 0, ra1: 0, ra2: 0, wa3: 0, rw: 0, m2r: 0, pc: 1}, "perf_br", 1'b0, dummy);
`ifdef HAZARD_PERF_EN
    #1;
    check("perf_stall_cnt", 64'(stall_cnt), 64'd3);
    check("perf_flush_cnt", 64'(flush_cnt), 64'd2);
`endif

    // Randomized traffic against the in-flight model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      x.valid = ($urandom_range(0, 9) != 0);
      x.ra1   = rtag();
      x.ra2   = rtag();
      x.wa3   = rtag();
      x.rw    = ($urandom_range(0, 3) != 0);
      x.m2r   = ($urandom_range(0, 2) == 0);
      x.pc    = ($urandom_range(0, 9) == 0);
      step(x, "rand", 1'b0, dummy);
    end
`ifdef HAZARD_PERF_EN
    #1;
    check("rand_stall_cnt", 64'(stall_cnt), 64'(exp_stall_cnt));
    check("rand_flush_cnt", 64'(flush_cnt), 64'(exp_flush_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
